trap_controller: RTL

- Machine-mode trap source paired with the core status block.
- Collects synchronous exceptions and the software, timer and external interrupts.
- Arbitrates them and sequences trap entry: a one-hot `trapTrigger` pulse, then mepc/mcause/mtval capture, then a PC redirect to mtvec. On mret it drives `trapReturn` and a redirect to mepc.
- Owns mie, mtvec, mepc, mcause, mtval, mip, and a machine timer (mtime/mtimecmp).

---
 rtl/trap_controller.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/trap_controller.sv
// Machine-mode trap controller: exception/interrupt arbitration, trap entry/return sequencing, trap CSRs and machine timer.
// Optional vectored interrupt dispatch via mtvec mode 01 is enabled by defining TRAP_VECTORED_EN.
module trap_controller #(
    parameter int unsigned   N         = 64,
    parameter logic [N-1:0]  RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          excValid,
    input  logic [3:0]    excCause,
    input  logic [N-1:0]  excTval,
    input  logic [N-1:0]  pcIn,
    input  logic          mretValid,
    input  logic          irqExt,
    input  logic          irqSw,
    input  logic          mstatusMIE,
    input  logic          csrWe,
    input  logic [11:0]   csrAddr,
    input  logic [N-1:0]  csrWdata,
    output logic [N-1:0]  csrRdata,
    output logic [15:0]   trapTrigger,
    output logic          trapReturn,
    output logic          stall,
    output logic          redirect,
    output logic [N-1:0]  trapPC
);

    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MTIME    = 12'h7C0;
    localparam logic [11:0] ADDR_MTIMECMP = 12'h7C1;

    localparam logic [N-1:0] MIE_MASK   = N'(12'h888);
    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        REDIRECT,
        RETURN
    } state_t;

    state_t        state_q;
    logic [N-1:0]  mie_q;
    logic [N-1:0]  mtvec_q;
    logic [N-1:0]  mepc_q;
    logic [N-1:0]  mcause_q;
    logic [N-1:0]  mtval_q;
    logic [N-1:0]  mtime_q;
    logic [N-1:0]  mtimecmp_q;

    // Trap context captured on acceptance, committed to the CSRs at the end of TAKE.
    logic [4:0]    cause_q;
    logic [N-1:0]  epc_q;
    logic [N-1:0]  tval_q;

    logic          mtip;
    logic [N-1:0]  mip;
    logic [N-1:0]  pending;
    logic          irq_req;
    logic [3:0]    irq_code;
    logic          in_idle;
    logic [N-1:0]  mtvec_base;
    logic [N-1:0]  trap_target;

    assign mtip       = (mtime_q >= mtimecmp_q);
    assign in_idle    = (state_q == IDLE);
    assign mtvec_base = mtvec_q & ALIGN_MASK;

    always_comb begin
        mip     = '0;
        mip[11] = irqExt;
        mip[7]  = mtip;
        mip[3]  = irqSw;
    end

    assign pending = mip & mie_q;
    assign irq_req = mstatusMIE && (pending != '0);

    always_comb begin
        if (pending[11])
            irq_code = 4'd11;
        else if (pending[3])
            irq_code = 4'd3;
        else
            irq_code = 4'd7;
    end

`ifdef TRAP_VECTORED_EN
    always_comb begin
        if (mtvec_q[1:0] == 2'b01 && cause_q[4])
            trap_target = mtvec_base + {{(N-6){1'b0}}, cause_q[3:0], 2'b00};
        else
            trap_target = mtvec_base;
    end
`else
    assign trap_target = mtvec_base;
`endif

    assign stall = !in_idle || excValid || irq_req || mretValid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cause_q     <= '0;
            epc_q       <= '0;
            tval_q      <= '0;
            trapTrigger <= '0;
            trapReturn  <= 1'b0;
            redirect    <= 1'b0;
            trapPC      <= '0;
        end else begin
            trapTrigger <= '0;
            trapReturn  <= 1'b0;
            redirect    <= 1'b0;
            trapPC      <= '0;
            case (state_q)
                IDLE: begin
                    if (excValid) begin
                        cause_q     <= {1'b0, excCause};
                        tval_q      <= excTval;
                        epc_q       <= pcIn;
                        trapTrigger <= 16'd1 << excCause;
                        state_q     <= TAKE;
                    end else if (irq_req) begin
                        cause_q     <= {1'b1, irq_code};
                        tval_q      <= '0;
                        epc_q       <= pcIn;
                        trapTrigger <= 16'd1 << irq_code;
                        state_q     <= TAKE;
                    end else if (mretValid) begin
                        trapReturn  <= 1'b1;
                        redirect    <= 1'b1;
                        trapPC      <= mepc_q;
                        state_q     <= RETURN;
                    end
                end
                TAKE: begin
                    redirect <= 1'b1;
                    trapPC   <= trap_target;
                    state_q  <= REDIRECT;
                end
                REDIRECT: state_q <= IDLE;
                RETURN:   state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mie_q      <= '0;
            mtvec_q    <= RESET_VEC;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            if (csrWe && csrAddr == ADDR_MTIME)
                mtime_q <= csrWdata;
            else
                mtime_q <= mtime_q + N'(1);

            if (csrWe) begin
                case (csrAddr)
                    ADDR_MIE:      mie_q      <= csrWdata & MIE_MASK;
`ifdef TRAP_VECTORED_EN
                    ADDR_MTVEC:    mtvec_q    <= csrWdata;
`else
                    ADDR_MTVEC:    mtvec_q    <= csrWdata & ALIGN_MASK;
`endif
                    ADDR_MTIMECMP: mtimecmp_q <= csrWdata;
                    default: ;
                endcase
            end

            // Trap commit overrides any software write to the trap-context CSRs.
            if (state_q == TAKE) begin
                mepc_q   <= epc_q & ALIGN_MASK;
                mcause_q <= {cause_q[4], {(N-5){1'b0}}, cause_q[3:0]};
                mtval_q  <= tval_q;
            end else if (csrWe) begin
                case (csrAddr)
                    ADDR_MEPC:   mepc_q   <= csrWdata & ALIGN_MASK;
                    ADDR_MCAUSE: mcause_q <= csrWdata;
                    ADDR_MTVAL:  mtval_q  <= csrWdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        csrRdata = '0;
        case (csrAddr)
            ADDR_MIE:      csrRdata = mie_q;
            ADDR_MTVEC:    csrRdata = mtvec_q;
            ADDR_MEPC:     csrRdata = mepc_q;
            ADDR_MCAUSE:   csrRdata = mcause_q;
            ADDR_MTVAL:    csrRdata = mtval_q;
            ADDR_MIP:      csrRdata = mip;
            ADDR_MTIME:    csrRdata = mtime_q;
            ADDR_MTIMECMP: csrRdata = mtimecmp_q;
            default:       csrRdata = '0;
        endcase
    end

endmodule
